mem_access_ctrl: RTL and testbench

//  Initiator side of the main-memory port: the pipeline MEM stage issues load/store

---
 rtl/mem_access_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl
//  Description : Initiator side of the main-memory port. Accepts one load or
//                store at a time from the pipeline MEM stage and drives
//                mem_main. Adds byte loads (sign/zero extended) and byte
//                stores, done as a read-modify-write of the 16-bit word.
//                busy stalls the pipeline while an access is in flight.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt_sys,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_byte,
    input  logic              req_hi,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              busy,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_data_in
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACCESS   = 2'd1,
        S_MERGE_WR = 2'd2,
        S_RESP     = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    // Request attributes captured at accept; req_* may change afterwards.
    logic                r_we;
    logic                r_byte;
    logic                r_hi;
    logic                r_signed;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_resp_data;

    logic                w_accept;
    logic                w_mem_we;
    logic                w_resp_valid;
    logic                w_busy;
    logic [7:0]          w_lane;
    logic [DATA_W-1:0]   w_load_data;
    logic [DATA_W-1:0]   w_merged;

    assign req_ready = (r_state == S_IDLE) && !halt_sys && rst;
    assign w_accept  = req_valid && req_ready;

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control outputs; halt freezes the FSM and blocks writes.
    always_comb begin
        w_state_nxt  = r_state;
        w_mem_we     = 1'b0;
        w_resp_valid = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (w_accept) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_we && r_byte) begin
                    w_state_nxt = S_MERGE_WR;
                end else begin
                    w_state_nxt = S_RESP;
                    w_mem_we    = r_we;
                end
            end
            S_MERGE_WR: begin
                w_state_nxt = S_RESP;
                w_mem_we    = 1'b1;
            end
            S_RESP: begin
                w_state_nxt  = S_IDLE;
                w_resp_valid = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (halt_sys) begin
            w_state_nxt = r_state;
            w_mem_we    = 1'b0;
        end
        if (!rst) begin
            w_mem_we = 1'b0;
        end
    end

    // Byte-load formatting and byte-store lane merge from the word just read.
    always_comb begin
        w_lane      = r_hi ? mem_data_in[15:8] : mem_data_in[7:0];
        w_load_data = mem_data_in;
        if (r_byte) begin
            w_load_data = {{(DATA_W-8){r_signed & w_lane[7]}}, w_lane};
        end
        w_merged = mem_data_in;
        if (r_hi) begin
            w_merged[15:8] = r_mem_wdata[7:0];
        end else begin
            w_merged[7:0]  = r_mem_wdata[7:0];
        end
    end

    // Datapath: capture request, then load result or merged store word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we        <= 1'b0;
            r_byte      <= 1'b0;
            r_hi        <= 1'b0;
            r_signed    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_resp_data <= '0;
        end else if (!halt_sys) begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we        <= req_we;
                        r_byte      <= req_byte;
                        r_hi        <= req_hi;
                        r_signed    <= req_signed;
                        r_mem_addr  <= req_addr;
                        r_mem_wdata <= req_wdata;
                    end
                end
                S_ACCESS: begin
                    if (!r_we) begin
                        r_resp_data <= w_load_data;
                    end else begin
                        r_resp_data <= '0;
                        if (r_byte) begin
                            r_mem_wdata <= w_merged;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign resp_valid     = w_resp_valid;
    assign resp_data      = r_resp_data;
    assign busy           = w_busy;
    assign mem_write_en   = w_mem_we;
    assign mem_address    = r_mem_addr;
    assign mem_write_data = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_ctrl
//  Description : Self-checking bench for mem_access_ctrl with a behavioural
//                mem_main model and a response scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        halt_sys;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_byte;
    logic        req_hi;
    logic        req_signed;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic        busy;
    logic        mem_write_en;
    logic [15:0] mem_address;
    logic [15:0] mem_write_data;
    logic [15:0] mem_data_in;

    mem_access_ctrl #(.ADDR_W(16), .DATA_W(16)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .halt_sys       (halt_sys),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_byte       (req_byte),
        .req_hi         (req_hi),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .busy           (busy),
        .mem_write_en   (mem_write_en),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_data_in    (mem_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mem_main model: combinational read, synchronous write
    logic [15:0] mem [0:65535];
    assign mem_data_in = mem[mem_address];
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_address] = mem_write_data;
    end

    typedef struct packed {
        logic [15:0] data;
        logic [7:0]  lat;
    } exp_t;

    exp_t sb[$];
    int   acc_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   wr_cnt = 0;
    int   last_wr = 0;
    int   last_acc = 0;
    int   busy_cnt = 0;
    int   acc_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: accepts, writes, busy cycles and scoreboard pops
    always @(negedge clk) begin
        if (rst) begin
            if (req_valid && req_ready) begin
                check_val("accept_in_idle", {31'd0, busy}, 32'd0);
                acc_q.push_back(cyc + 1);
                acc_cnt++;
            end
            if (mem_write_en) begin
                wr_cnt++;
                last_wr = cyc;
            end
            if (busy) busy_cnt++;
            if (resp_valid && !halt_sys) begin
                if (sb.size() == 0 || acc_q.size() == 0) begin
                    check_val("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    int   a;
                    e = sb.pop_front();
                    a = acc_q.pop_front();
                    last_acc = a;
                    check_val("resp_data", {16'd0, resp_data}, {16'd0, e.data});
                    check_val("resp_latency", cyc - a, {24'd0, e.lat} - 32'd1);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until accepted; req_valid stays high.
    task automatic issue(input logic we, input logic byt, input logic hi, input logic sgn,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] exp_d, input int lat);
        exp_t e;
        int   n;
        logic ok;
        req_we     = we;
        req_byte   = byt;
        req_hi     = hi;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        e.data = exp_d;
        e.lat  = lat[7:0];
        sb.push_back(e);
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = req_ready;
            n++;
        end
        if (!ok) check_val("accept_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            check_val("resp_timeout", sb.size(), 32'd0);
            sb.delete();
            acc_q.delete();
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        int acc0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        rst        = 1'b0;
        halt_sys   = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_byte   = 1'b0;
        req_hi     = 1'b0;
        req_signed = 1'b0;
        req_addr   = 16'h0000;
        req_wdata  = 16'h0000;

        // Reset values
        tick();
        tick();
        @(negedge clk);
        check_val("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_val("rst_mem_we", {31'd0, mem_write_en}, 32'd0);
        check_val("rst_mem_addr", {16'd0, mem_address}, 32'd0);
        check_val("rst_mem_wdata", {16'd0, mem_write_data}, 32'd0);
        check_val("rst_resp_data", {16'd0, resp_data}, 32'd0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_val("idle_req_ready", {31'd0, req_ready}, 32'd1);
        tick();

        // Word store then word load
        issue(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 2);
        req_valid = 1'b0;
        drain();
        check_val("ws_write_cycle", last_wr - last_acc, 32'd0);
        check_val("ws_mem", {16'd0, mem[16'h0010]}, 32'h0000BEEF);
        issue(1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 2);
        req_valid = 1'b0;
        drain();

        // Byte loads
        mem[16'h0020] = 16'h12F4;
        issue(1'b0, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0012, 2);
        issue(1'b0, 1'b1, 1'b0, 1'b1, 16'h0020, 16'h0000, 16'hFFF4, 2);
        issue(1'b0, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h00F4, 2);
        issue(1'b0, 1'b1, 1'b1, 1'b1, 16'h0020, 16'h0000, 16'h0012, 2);
        req_valid = 1'b0;
        drain();

        // Byte store read-modify-write
        mem[16'h0030] = 16'hAAAA;
        wr0      = wr_cnt;
        busy_cnt = 0;
        issue(1'b1, 1'b1, 1'b1, 1'b0, 16'h0030, 16'hFF55, 16'h0000, 3);
        req_valid = 1'b0;
        drain();
        check_val("bs_write_count", wr_cnt - wr0, 32'd1);
        check_val("bs_write_cycle", last_wr - last_acc, 32'd1);
        check_val("bs_busy_cycles", busy_cnt, 32'd3);
        check_val("bs_mem_hi", {16'd0, mem[16'h0030]}, 32'h000055AA);
        mem[16'h0031] = 16'h1234;
        issue(1'b1, 1'b1, 1'b0, 1'b0, 16'h0031, 16'h00C3, 16'h0000, 3);
        req_valid = 1'b0;
        drain();
        check_val("bs_mem_lo", {16'd0, mem[16'h0031]}, 32'h000012C3);

        // Halt during ACCESS of a word store
        wr0 = wr_cnt;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 16'h0050, 16'h1357, 16'h0000, 5);
        req_valid = 1'b0;
        halt_sys  = 1'b1;
        tick();
        tick();
        tick();
        check_val("halt_no_write", wr_cnt - wr0, 32'd0);
        check_val("halt_mem", {16'd0, mem[16'h0050]}, 32'd0);
        halt_sys = 1'b0;
        drain();
        check_val("halt_write_cycle", last_wr - last_acc, 32'd3);
        check_val("halt_mem_after", {16'd0, mem[16'h0050]}, 32'h00001357);

        // Back-to-back with req_valid held high
        acc0 = acc_cnt;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hA5A5, 16'h0000, 2);
        issue(1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'hA5A5, 2);
        issue(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h5A5A, 16'h0000, 2);
        issue(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h5A5A, 2);
        req_valid = 1'b0;
        drain();
        check_val("b2b_accepts", acc_cnt - acc0, 32'd4);
        check_val("b2b_mem_ffff", {16'd0, mem[16'hFFFF]}, 32'h0000A5A5);
        check_val("b2b_mem_0000", {16'd0, mem[16'h0000]}, 32'h00005A5A);

        // Reset during MERGE_WR of a byte store
        mem[16'h0040] = 16'h1234;
        wr0        = wr_cnt;
        req_we     = 1'b1;
        req_byte   = 1'b1;
        req_hi     = 1'b1;
        req_signed = 1'b0;
        req_addr   = 16'h0040;
        req_wdata  = 16'h0077;
        req_valid  = 1'b1;
        @(negedge clk);
        check_val("rm_ready", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        tick();
        check_val("rm_we_before", {31'd0, mem_write_en}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_val("rm_we_after", {31'd0, mem_write_en}, 32'd0);
        check_val("rm_busy", {31'd0, busy}, 32'd0);
        tick();
        check_val("rm_mem", {16'd0, mem[16'h0040]}, 32'h00001234);
        check_val("rm_write_count", wr_cnt - wr0, 32'd0);
        acc_q.delete();
        sb.delete();
        rst = 1'b1;
        @(negedge clk);
        check_val("rm_ready_rel", {31'd0, req_ready}, 32'd1);
        check_val("rm_busy_rel", {31'd0, busy}, 32'd0);
        check_val("rm_resp_valid", {31'd0, resp_valid}, 32'd0);
        tick();

        // Post-reset sanity access
        issue(1'b0, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h1234, 2);
        req_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
